fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, at least 2.
REQ-002 SHALL have parameter ENT_NUM, default 4: entry count of the downstream one-in-one-out FIFO, at least 2.
REQ-003 SHALL have parameter DATA_SIZE, default 32: payload width.
REQ-004 SHALL have derived parameter CRD_WIDTH, default $clog2(ENT_NUM+1): credit counter width.
REQ-005 clk  input  1  sole clock, rising edge; one clock, reset is asynchronous and active-low.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_REQ  per-requester write request.
REQ-008 req_data  input  NUM_REQ*DATA_SIZE  payloads; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
REQ-009 gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as req.
REQ-010 fifo_in_vld  output  1  registered write strobe to the FIFO in_vld.
REQ-011 fifo_in_data  output  DATA_SIZE  registered payload to the FIFO in_data.
REQ-012 fifo_take  input  1  FIFO out_vld & pick_rdy, meaning one entry drained this cycle.
REQ-013 crd_cnt  output  CRD_WIDTH  free-entry credits.
REQ-014 no_crd  output  1  crd_cnt == 0.

Function
REQ-015 SHALL grant at most one requester per cycle, by round-robin starting at rr_ptr.
REQ-016 SHALL assert no gnt when crd_cnt == 0; there is no same-cycle credit bypass from fifo_take.
REQ-017 On grant to requester k, rr_ptr SHALL become (k+1) mod NUM_REQ at the next edge; with no grant, rr_ptr SHALL hold.
REQ-018 fifo_in_vld SHALL be 1 in the cycle after a grant and 0 otherwise; fifo_in_data SHALL be the granted requester's req_data captured at the grant edge. Latency is 1 cycle.
REQ-019 fifo_in_data SHALL hold its value when no grant occurs.
REQ-020 crd_cnt update rules, applied at each edge:
- grant only: decrement by 1.
- fifo_take only: increment by 1.
- grant and fifo_take together: unchanged.
REQ-021 crd_cnt SHALL never exceed ENT_NUM or go below 0.
- fifo_take with crd_cnt == ENT_NUM is a protocol error: the count saturates, and the assertion in REQ-035 fires.
REQ-022 By construction, the FIFO SHALL never receive a write while it is full, so no FIFO entry is ever overwritten.
REQ-023 A requester SHALL hold req and req_data stable until it sees gnt; a deasserted req is simply not considered.
REQ-024 A single active requester SHALL be granted every cycle while credits remain.
REQ-025 A requester waiting on another SHALL be granted within NUM_REQ-1 grants.

Reset
REQ-026 While rst_n = 0, registers SHALL reset asynchronously to:
- rr_ptr = 0, crd_cnt = ENT_NUM, fifo_in_vld = 0, fifo_in_data = 0.
- lock state = IDLE (when REQ-028 is compiled in).
REQ-027 Reset asserted mid-transfer SHALL discard any pending write. The FIFO SHALL be reset from the same rst_n, so the credits stay consistent.

Configuration
REQ-028 With macro FIFO_WR_ARB_LOCK_EN defined, the block SHALL add:
- Input req_lock (NUM_REQ bits).
- A 2-state FSM with states IDLE and LOCKED.
REQ-029 FSM transitions:
- IDLE to LOCKED: on a grant to k with req_lock[k] = 1.
- LOCKED: grant stays on k while req[k] & req_lock[k] and crd_cnt > 0; rr_ptr is frozen.
- LOCKED to IDLE: when req[k] & req_lock[k] drops. rr_ptr then becomes (k+1) mod NUM_REQ.
REQ-030 With FIFO_WR_ARB_LOCK_EN undefined, there is no req_lock port and no FSM; behaviour is pure round-robin.

Structure
REQ-031 A shared package SHALL hold:
- The FSM state typedef (IDLE, LOCKED).
- The default ENT_NUM, NUM_REQ and DATA_SIZE constants.
REQ-032 One sub-module rr_arb_lib SHALL implement the combinational round-robin pick: inputs req and rr_ptr, outputs one-hot gnt and the encoded index.
REQ-033 Credit counter, output registers and FSM SHALL live in fifo_wr_arb.

Verification
REQ-034 The bench SHALL cover these directed scenarios (defaults unless stated):
- Reset then req = 4'b1111 held, fifo_take = 0: gnt sequence 0001, 0010, 0100, 1000, then gnt = 0 with crd_cnt = 0 and no_crd = 1.
- From empty, req = 4'b0100 and fifo_take = 1 every cycle after the first write: gnt[2] every cycle; crd_cnt steady at 3 after the first grant.
- Grant to requester 1 with req_data[1] = 32'hDEAD_BEEF: next cycle fifo_in_vld = 1 and fifo_in_data = 32'hDEAD_BEEF.
- Credits 0, fifo_take = 1 in cycle t with req pending: no gnt in cycle t; gnt in cycle t+1.
- Reset asserted while crd_cnt = 1: crd_cnt = 4, fifo_in_vld = 0, next grant goes to requester 0.
- LOCK_EN: req = 4'b0011, req_lock[1] = 1, requester 1 granted: requester 1 granted for 3 consecutive cycles. Lock drops, then requester 0 is granted.
REQ-035 The bench SHALL assert on every cycle that:
- gnt is one-hot or zero.
- crd_cnt equals ENT_NUM minus FIFO occupancy.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// The lock FSM state type is used only when FIFO_WR_ARB_LOCK_EN is defined.
package fifo_wr_arb_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_ENT_NUM   = 4;
    localparam int unsigned DEF_DATA_SIZE = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Round-robin successor of idx among n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb_lib.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping.
// Produces a one-hot grant and the matching encoded index.
module rr_arb_lib #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic        found;
    int unsigned k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                gnt[k]  = 1'b1;
                gnt_idx = IDX_W'(k);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Credit-based round-robin write arbiter in front of a one-in-one-out FIFO.
// Define FIFO_WR_ARB_LOCK_EN to add the req_lock port and the burst-lock FSM.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned ENT_NUM   = DEF_ENT_NUM,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned CRD_WIDTH = $clog2(ENT_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
`ifdef FIFO_WR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           req_lock,
`endif
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         fifo_in_vld,
    output logic [DATA_SIZE-1:0]         fifo_in_data,
    input  logic                         fifo_take,
    output logic [CRD_WIDTH-1:0]         crd_cnt,
    output logic                         no_crd
);

    localparam int unsigned          IDX_W    = $clog2(NUM_REQ);
    localparam logic [CRD_WIDTH-1:0] CRD_FULL = CRD_WIDTH'(ENT_NUM);

    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CRD_WIDTH-1:0] crd_q, crd_d;
    logic                 vld_q;
    logic [DATA_SIZE-1:0] data_q;

    logic                 crd_avail;
    logic [NUM_REQ-1:0]   arb_req, arb_gnt, gnt_int;
    logic [IDX_W-1:0]     arb_idx, sel_idx;
    logic                 grant;

    // No same-cycle bypass: only credits already held can be spent.
    assign crd_avail = (crd_q != '0);
    assign arb_req   = req & {NUM_REQ{crd_avail}};

    rr_arb_lib #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req     (arb_req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

`ifdef FIFO_WR_ARB_LOCK_EN
    lock_state_e      state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             lock_hold;

    assign lock_hold = (state_q == LOCKED) && req[lock_idx_q] && req_lock[lock_idx_q];

    // rr_ptr already moved past the locked requester on the grant that entered
    // LOCKED; it stays frozen, so leaving the lock resumes from k+1.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_int    = arb_gnt;
        sel_idx    = arb_idx;
        if (lock_hold) begin
            gnt_int = '0;
            sel_idx = lock_idx_q;
            if (crd_avail) begin
                gnt_int[lock_idx_q] = 1'b1;
            end
        end else begin
            state_d = IDLE;
            if (|arb_gnt) begin
                rr_ptr_d   = IDX_W'(rr_next(32'(arb_idx), NUM_REQ));
                lock_idx_d = arb_idx;
                if (req_lock[arb_idx]) begin
                    state_d = LOCKED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    always_comb begin
        gnt_int  = arb_gnt;
        sel_idx  = arb_idx;
        rr_ptr_d = rr_ptr_q;
        if (|arb_gnt) begin
            rr_ptr_d = IDX_W'(rr_next(32'(arb_idx), NUM_REQ));
        end
    end
`endif

    assign grant = |gnt_int;

    // A take with the counter full is a protocol error; saturate instead of wrapping.
    always_comb begin
        crd_d = crd_q;
        unique case ({grant, fifo_take})
            2'b10:   crd_d = crd_q - 1'b1;
            2'b01:   if (crd_q != CRD_FULL) crd_d = crd_q + 1'b1;
            default: crd_d = crd_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            crd_q    <= CRD_FULL;
            vld_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            crd_q    <= crd_d;
            vld_q    <= grant;
            if (grant) begin
                data_q <= req_data[32'(sel_idx) * DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign gnt          = gnt_int;
    assign fifo_in_vld  = vld_q;
    assign fifo_in_data = data_q;
    assign crd_cnt      = crd_q;
    assign no_crd       = (crd_q == '0);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed scenarios plus a per-cycle
// scoreboard and credit/occupancy model of a bypass-capable FIFO.
module tb_fifo_wr_arb;

    localparam int NUM_REQ   = 4;
    localparam int ENT_NUM   = 4;
    localparam int DATA_SIZE = 32;
    localparam int CRD_WIDTH = 3;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           gnt;
    logic                         fifo_in_vld;
    logic [DATA_SIZE-1:0]         fifo_in_data;
    logic                         fifo_take;
    logic [CRD_WIDTH-1:0]         crd_cnt;
    logic                         no_crd;
`ifdef FIFO_WR_ARB_LOCK_EN
    logic [NUM_REQ-1:0]           req_lock;
`endif

    int              n_tests = 0;
    int              n_fail  = 0;
    logic [31:0]     exp_q[$];
    logic [31:0]     mem[$];
    logic            prev_gnt = 1'b0;
    logic            take_en;
    logic [3:0]      s1_seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NUM_REQ   (NUM_REQ),
        .ENT_NUM   (ENT_NUM),
        .DATA_SIZE (DATA_SIZE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
`ifdef FIFO_WR_ARB_LOCK_EN
        .req_lock     (req_lock),
`endif
        .gnt          (gnt),
        .fifo_in_vld  (fifo_in_vld),
        .fifo_in_data (fifo_in_data),
        .fifo_take    (fifo_take),
        .crd_cnt      (crd_cnt),
        .no_crd       (no_crd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; the FIFO output is valid if it holds data or a write is landing.
    task automatic tick();
        @(posedge clk);
        #1;
        fifo_take = take_en && ((mem.size() > 0) || fifo_in_vld);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        take_en   = 1'b0;
        fifo_take = 1'b0;
`ifdef FIFO_WR_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        req     = '0;
        take_en = 1'b1;
        for (int i = 0; i < 12 && crd_cnt != CRD_WIDTH'(ENT_NUM); i++) tick();
        @(negedge clk);
        check("drain_crd", 32'(crd_cnt), ENT_NUM);
        take_en = 1'b0;
        tick();
    endtask

    // Per-cycle monitor: one-hot grant, credit vs occupancy, latency and payload.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mem.delete();
                prev_gnt = 1'b0;
            end else begin
                check("gnt_onehot0", 32'($onehot0(gnt)), 1);
                check("crd_occ", 32'(crd_cnt), 32'(ENT_NUM - mem.size() - int'(fifo_in_vld)));
                check("no_crd", 32'(no_crd), 32'(crd_cnt == 0));
                check("vld_latency", 32'(fifo_in_vld), 32'(prev_gnt));
                if (fifo_in_vld) begin
                    check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("sb_data", fifo_in_data, exp_q.pop_front());
                    mem.push_back(fifo_in_data);
                end
                for (int i = 0; i < NUM_REQ; i++)
                    if (gnt[i]) exp_q.push_back(req_data[i*DATA_SIZE +: DATA_SIZE]);
                if (fifo_take) begin
                    check("take_nonempty", 32'(mem.size() != 0), 1);
                    if (mem.size() != 0) void'(mem.pop_front());
                end
                prev_gnt = |gnt;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hDEAD_BEEF, 32'h1234_5678};
        do_reset();
        @(negedge clk);
        check("rst_crd", 32'(crd_cnt), ENT_NUM);
        check("rst_vld", 32'(fifo_in_vld), 0);
        check("rst_data", fifo_in_data, 0);
        check("rst_no_crd", 32'(no_crd), 0);

        // All requesters active, no drain: rotate through 0..3 then run dry.
        tick();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s1_gnt", 32'(gnt), 32'(s1_seq[i]));
            if (i == 2) begin
                check("s3_vld", 32'(fifo_in_vld), 1);
                check("s3_data", fifo_in_data, 32'hDEAD_BEEF);
            end
            if (i < 4) tick();
        end
        check("s1_crd_zero", 32'(crd_cnt), 0);
        check("s1_no_crd", 32'(no_crd), 1);

        // Credit returns in cycle t: no grant in t, grant in t+1.
        take_en = 1'b1;
        tick();
        @(negedge clk);
        check("s4_no_bypass", 32'(gnt), 0);
        tick();
        @(negedge clk);
        check("s4_gnt_next", 32'(gnt), 32'(4'b0001));
        take_en = 1'b0;
        tick();
        req = '0;
        @(negedge clk);
        check("s5_pre_crd", 32'(crd_cnt), 1);
        check("s5_pre_vld", 32'(fifo_in_vld), 1);

        // Asynchronous reset with a write in flight.
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_crd", 32'(crd_cnt), ENT_NUM);
        check("s5_rst_vld", 32'(fifo_in_vld), 0);
        check("s5_rst_data", fifo_in_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        check("s5_gnt_after_rst", 32'(gnt), 32'(4'b0001));
        tick();
        drain();

        // Single requester with continuous drain.
        take_en = 1'b1;
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("s2_gnt", 32'(gnt), 32'(4'b0100));
            if (i >= 1) check("s2_crd", 32'(crd_cnt), 3);
            tick();
        end
        drain();

        do_reset();
        take_en = 1'b1;
        req = 4'b0011;
`ifdef FIFO_WR_ARB_LOCK_EN
        req_lock = 4'b0010;
        @(negedge clk);
        check("lk_first", 32'(gnt), 32'(4'b0001));
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("lk_hold", 32'(gnt), 32'(4'b0010));
        end
        tick();
        req_lock = '0;
        @(negedge clk);
        check("lk_release", 32'(gnt), 32'(4'b0001));
`else
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_alt", 32'(gnt), (i % 2 == 0) ? 32'(4'b0001) : 32'(4'b0010));
            tick();
        end
`endif
        tick();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
